t05_sram_responder: RTL

//  Memory-side responder for the team-05 SRAM bus driven by the SRAM interface
//  (wr_en/r_en/select/addr/data_i out; data_o/busy_o in). Decodes a word-addressed

---
 rtl/t05_sram_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/t05_sram_responder.sv
// ============================================================================
// Module      : t05_sram_responder
// Description : Memory-side responder for the team-05 SRAM bus. Decodes a
//               word-addressed window starting at BASE_ADDR and holds a
//               DEPTH x 32 memory. Each accepted request keeps busy_o high
//               for exactly LATENCY cycles. The operation executes on the
//               edge where busy_o falls, which tells the initiator it is done.
// Ports       : clk     in   system clock, all state on posedge
//               nrst    in   asynchronous active-low reset
//               wr_en   in   write request (level)
//               r_en    in   read request (level); wr_en wins if both high
//               select  in   byte-lane enables for writes
//               addr    in   byte address, addr[1:0] ignored
//               data_i  in   write data
//               data_o  out  read data, held until the next read completes
//               busy_o  out  transaction in progress
//               err_o   out  one-cycle pulse: completed access missed window
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t05_sram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h3300_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_en,
    input  logic        r_en,
    input  logic [3:0]  select,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One past the last byte of the window, kept at 33 bits so a window
    // that ends exactly at 4 GiB does not wrap to zero.
    localparam logic [32:0] WIN_END  = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        op_write;
    logic [3:0]  sel_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH];

    logic          in_window;
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          done;
    logic          unused_offset_bits;

    // Decode always works on the captured address, so the initiator may
    // change addr freely while the transaction is in flight.
    assign in_window = ({1'b0, addr_q} >= {1'b0, BASE_ADDR}) &&
                       ({1'b0, addr_q} <  WIN_END);
    assign offset    = addr_q - BASE_ADDR;
    assign word_idx  = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[31:AW+2], offset[1:0]};

    // Completion edge: last BUSY cycle with the countdown exhausted.
    assign done = (state == ST_BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            op_write <= 1'b0;
            sel_q    <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            busy_o   <= 1'b0;
            data_o   <= 32'd0;
            err_o    <= 1'b0;
        end else begin
            // err_o is a single-cycle pulse; it is only raised on completion.
            err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_en || r_en) begin
                        addr_q   <= addr;
                        sel_q    <= select;
                        wdata_q  <= data_i;
                        op_write <= wr_en;
                        busy_o   <= 1'b1;
                        cnt      <= CNT_LOAD;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        busy_o <= 1'b0;
                        err_o  <= !in_window;
                        state  <= ST_IDLE;
                        if (!op_write) begin
                            data_o <= in_window ? mem[word_idx] : 32'd0;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Memory is deliberately not reset. A write still pending when nrst
    // asserts never lands, because reset forces the FSM out of BUSY
    // asynchronously and 'done' drops with it.
    always_ff @(posedge clk) begin
        if (done && op_write && in_window) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (sel_q[lane]) begin
                    mem[word_idx][8*lane +: 8] <= wdata_q[8*lane +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire
